jesd204_crc12_mb_sequencer: RTL

//  TX-side sequencer for the JESD204C 64b66b CRC-12 engine. Tracks block position within each
//  32-block multiblock and drives the engine's init strobe on block 0. Latches the finished
//  CRC-12 and serialises it, with a 9-bit command field and framing bits, into the per-block

---
 rtl/jesd204_crc12_mb_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/jesd204_crc12_mb_sequencer.sv
// Purpose : TX CRC-12 multiblock sequencer; tracks block position, strobes engine init on block 0
//           and serialises {CRC-12, 9-bit cmd, framing} into the next multiblock's sync headers.
// Latency : all out_* registered, 1 cycle after the block on in_data; crc_init is combinational.
// Backpr. : none; one block per cycle while enable=1, enable=0 aborts to IDLE.
//
// Ports:
//   clk, reset          link clock, synchronous active-high reset
//   enable              link active
//   mb_start            current block is multiblock position 0
//   in_data / in_cmd    scrambled block data / command field (sampled at position 0)
//   crc_init            init strobe to the CRC engine (engine consumes in_data directly)
//   crc12               CRC engine state
//   out_valid/out_data  registered block valid / in_data delayed one cycle
//   out_sh / out_pos    sync-header stream bit / multiblock position of the output block
//   out_crc_valid       this multiblock's header carries a genuine CRC
//   align_err           one-cycle pulse on an unexpected mb_start
module jesd204_crc12_mb_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mb_start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [8:0]       in_cmd,
    output logic             crc_init,
    input  logic [11:0]      crc12,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sh,
    output logic [4:0]       out_pos,
    output logic             out_crc_valid,
    output logic             align_err
);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN} state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [4:0]  r_pos;
    logic [4:0]  w_pos_inc;
    logic [4:0]  w_pos;
    logic [11:0] r_crc_hold;
    logic [8:0]  r_cmd_hold;
    logic        w_misalign;
    logic        w_blk_vld;
    logic        w_mb0;
    logic [11:0] w_crc;
    logic [8:0]  w_cmd;
    logic        w_sh;

    assign w_pos_inc  = r_pos + 5'd1;
    assign w_pos      = mb_start ? 5'd0 : w_pos_inc;
    // mb_start landing on the natural wrap is not an alignment error.
    assign w_misalign = enable & mb_start & (r_state != S_IDLE) & (w_pos_inc != 5'd0);

    always_comb begin
        w_nxt = r_state;
        if (!enable) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (mb_start) w_nxt = S_FIRST;
                S_FIRST: begin
                    if (w_misalign)          w_nxt = S_FIRST;
                    else if (w_pos == 5'd0)  w_nxt = S_RUN;
                end
                S_RUN:   if (w_misalign) w_nxt = S_FIRST;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // The next state is the state the current block belongs to: the block that
    // opens a multiblock already carries that multiblock's FIRST/RUN status.
    assign w_blk_vld = (w_nxt != S_IDLE);
    assign w_mb0     = w_blk_vld & (w_pos == 5'd0);
    assign crc_init  = ~reset & w_mb0;

    // Header bit 0 is taken straight from the engine; the rest come from the hold registers.
    assign w_crc = w_mb0 ? ((w_nxt == S_RUN) ? crc12 : 12'd0) : r_crc_hold;
    assign w_cmd = w_mb0 ? in_cmd : r_cmd_hold;

    always_comb begin
        w_sh = 1'b0;
        case (w_pos)
            5'd0:  w_sh = w_crc[11];  5'd1:  w_sh = w_crc[10];  5'd2:  w_sh = w_crc[9];
            5'd4:  w_sh = w_crc[8];   5'd5:  w_sh = w_crc[7];   5'd6:  w_sh = w_crc[6];
            5'd8:  w_sh = w_crc[5];   5'd9:  w_sh = w_crc[4];   5'd10: w_sh = w_crc[3];
            5'd12: w_sh = w_crc[2];   5'd13: w_sh = w_crc[1];   5'd14: w_sh = w_crc[0];
            5'd16: w_sh = w_cmd[8];   5'd17: w_sh = w_cmd[7];   5'd18: w_sh = w_cmd[6];
            5'd20: w_sh = w_cmd[5];   5'd21: w_sh = w_cmd[4];   5'd22: w_sh = w_cmd[3];
            5'd24: w_sh = w_cmd[2];   5'd25: w_sh = w_cmd[1];   5'd26: w_sh = w_cmd[0];
            5'd3, 5'd7, 5'd11, 5'd15, 5'd19, 5'd23, 5'd31: w_sh = 1'b1;
            default: w_sh = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pos         <= 5'd0;
            r_crc_hold    <= 12'd0;
            r_cmd_hold    <= 9'd0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sh        <= 1'b0;
            out_pos       <= 5'd0;
            out_crc_valid <= 1'b0;
            align_err     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pos   <= w_pos;
            if (w_mb0) begin
                r_crc_hold <= w_crc;
                r_cmd_hold <= in_cmd;
            end
            out_valid     <= w_blk_vld;
            out_data      <= in_data;
            out_sh        <= w_blk_vld & w_sh;
            out_pos       <= w_blk_vld ? w_pos : 5'd0;
            out_crc_valid <= (w_nxt == S_RUN);
            align_err     <= w_misalign;
        end
    end

endmodule
